// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: parses 'l'/'a' + MMSS + CR load commands and '@' alarm toggles.
// Optional echo/status output on tx_data is enabled by defining CMD_ECHO_EN.
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  CR_CHAR     = 8'h0d
) (
  input  logic        clk12m,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] ld_digits,
  output logic        alarm_en,
  output logic        cmd_err,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] ChLoadTime  = 8'h6c;  // 'l'
  localparam logic [7:0] ChLoadAlarm = 8'h61;  // 'a'
  localparam logic [7:0] ChToggle    = 8'h40;  // '@'
  localparam logic [7:0] ChEsc       = 8'h1b;
  localparam logic [7:0] ChZero      = 8'h30;
  localparam logic [7:0] ChFive      = 8'h35;
  localparam logic [7:0] ChNine      = 8'h39;

  typedef enum logic [1:0] {StIdle, StDig, StWaitCr} state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            is_alarm_q, is_alarm_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     digits_q, digits_d;
  logic            ld_time_q, ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic            alarm_en_q, alarm_en_d;
  logic            cmd_err_q, cmd_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            digit_ok;
  logic            is_cmd;

  // Tens digits (even index) are limited to 0..5.
  assign digit_ok = (rx_data >= ChZero) && (rx_data <= ChNine) &&
                    (idx_q[0] || (rx_data <= ChFive));
  assign is_cmd   = (rx_data == ChLoadTime) || (rx_data == ChLoadAlarm);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    is_alarm_d = is_alarm_q;
    shadow_d   = shadow_q;
    digits_d   = digits_q;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    cmd_err_d  = 1'b0;
    alarm_en_d = alarm_en_q;
    cnt_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (rx_data_rdy) begin
          if (is_cmd) begin
            state_d    = StDig;
            idx_d      = 2'd0;
            is_alarm_d = (rx_data == ChLoadAlarm);
          end else if (rx_data == ChToggle) begin
            alarm_en_d = ~alarm_en_q;
          end
        end
      end
      StDig, StWaitCr: begin
        if (rx_data_rdy) begin
          if (is_cmd) begin
            state_d    = StDig;
            idx_d      = 2'd0;
            is_alarm_d = (rx_data == ChLoadAlarm);
          end else if (rx_data == ChEsc) begin
            state_d = StIdle;
          end else if ((state_q == StDig) && digit_ok) begin
            shadow_d[4*(3-int'(idx_q)) +: 4] = rx_data[3:0];
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = StWaitCr;
          end else if ((state_q == StWaitCr) && (rx_data == CR_CHAR)) begin
            state_d    = StIdle;
            digits_d   = shadow_q;
            ld_time_d  = ~is_alarm_q;
            ld_alarm_d = is_alarm_q;
          end else begin
            state_d   = StIdle;
            cmd_err_d = 1'b1;
          end
        end else if (cnt_q == TmoLast) begin
          state_d   = StIdle;
          cmd_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk12m or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      is_alarm_q <= 1'b0;
      shadow_q   <= 16'h0000;
      digits_q   <= 16'h0000;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      alarm_en_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_alarm_q <= is_alarm_d;
      shadow_q   <= shadow_d;
      digits_q   <= digits_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      alarm_en_q <= alarm_en_d;
      cmd_err_q  <= cmd_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ld_time   = ld_time_q;
  assign ld_alarm  = ld_alarm_q;
  assign ld_digits = digits_q;
  assign alarm_en  = alarm_en_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = (state_q != StIdle);

`ifdef CMD_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_rdy_q, tx_rdy_d;

  // Errors (bad byte or timeout) report '?' in place of the echo.
  always_comb begin
    tx_rdy_d  = rx_data_rdy || cmd_err_d;
    tx_data_d = tx_data_q;
    if (cmd_err_d)        tx_data_d = 8'h3f;
    else if (rx_data_rdy) tx_data_d = rx_data;
  end

  always_ff @(posedge clk12m or posedge rst) begin
    if (rst) begin
      tx_data_q <= 8'h00;
      tx_rdy_q  <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_rdy_q;
`else
  assign tx_data     = 8'h00;
  assign tx_data_rdy = 1'b0;
`endif

endmodule
